// File: rtl/axi_ram_slave.sv
// AXI3-style slave backed by a single-port, byte-writable word RAM.
// Independent read and write FSMs share the RAM port; write beats win arbitration.
module axi_ram_slave #(
    parameter int unsigned RAM_DEPTH_LOG2 = 12
) (
    input  logic        clock,
    input  logic        reset_,
    // read address channel
    input  logic [3:0]  axi_read_address_id,
    input  logic [31:0] axi_read_address,
    input  logic [7:0]  axi_read_address_length,
    input  logic [2:0]  axi_read_address_size,
    input  logic [1:0]  axi_read_address_burst,
    input  logic        axi_read_address_valid,
    output logic        axi_read_address_ready,
    // read data channel
    output logic [3:0]  axi_read_data_id,
    output logic [31:0] axi_read_data,
    output logic [1:0]  axi_read_data_response,
    output logic        axi_read_data_last,
    output logic        axi_read_data_valid,
    input  logic        axi_read_data_ready,
    // write address channel
    input  logic [3:0]  axi_write_address_id,
    input  logic [31:0] axi_write_address,
    input  logic [7:0]  axi_write_address_length,
    input  logic [2:0]  axi_write_address_size,
    input  logic [1:0]  axi_write_address_burst,
    input  logic        axi_write_address_valid,
    output logic        axi_write_address_ready,
    // write data channel
    input  logic [3:0]  axi_write_data_id,
    input  logic [31:0] axi_write_data,
    input  logic [3:0]  axi_write_data_strobe,
    input  logic        axi_write_data_last,
    input  logic        axi_write_data_valid,
    output logic        axi_write_data_ready,
    // write response channel
    output logic [3:0]  axi_write_responce_id,
    output logic [1:0]  axi_write_responce,
    output logic        axi_write_responce_valid,
    input  logic        axi_write_responce_ready
);

    localparam int unsigned ADDR_TOP = RAM_DEPTH_LOG2 + 2;
    localparam int unsigned WORDS    = 1 << RAM_DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {RIdle, RAccess, RData} r_state_t;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_t;

    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [2:0] size);
        if ((addr >> ADDR_TOP) != 32'd0) begin
            return RESP_DECERR;
        end else if (size > 3'd2) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (burst == 2'b00) begin
            return addr;
        end
        return addr + (32'd1 << size);
    endfunction

    // Encodings are ordered so the numerically larger response is the more severe one.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [31:0] mem [WORDS];

    r_state_t    r_state;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_beat;

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [7:0]  w_beat;
    logic [1:0]  w_err;

    logic                      write_grant;
    logic                      mem_we;
    logic [1:0]                r_resp_now;
    logic [1:0]                w_resp_now;
    logic [1:0]                w_beat_err;
    logic                      w_final;
    logic [RAM_DEPTH_LOG2-1:0] r_idx;
    logic [RAM_DEPTH_LOG2-1:0] w_idx;
    logic                      unused_wid;

    assign unused_wid = ^axi_write_data_id;

    assign r_idx      = r_addr[RAM_DEPTH_LOG2+1:2];
    assign w_idx      = w_addr[RAM_DEPTH_LOG2+1:2];
    assign r_resp_now = beat_resp(r_addr, r_size);
    assign w_resp_now = beat_resp(w_addr, w_size);
    assign w_final    = (w_beat == w_len);
    assign w_beat_err = worst(w_resp_now,
                              (axi_write_data_last != w_final) ? RESP_SLVERR : RESP_OKAY);

    assign axi_write_data_ready = (w_state == WData);
    assign write_grant          = (w_state == WData) && axi_write_data_valid;
    assign mem_we               = write_grant && (w_resp_now == RESP_OKAY);

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_write_data_strobe[b]) begin
                    mem[w_idx][8*b +: 8] <= axi_write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state                <= RIdle;
            axi_read_address_ready <= 1'b0;
            r_id                   <= '0;
            r_addr                 <= '0;
            r_len                  <= '0;
            r_size                 <= '0;
            r_burst                <= '0;
            r_beat                 <= '0;
            axi_read_data_id       <= '0;
            axi_read_data          <= '0;
            axi_read_data_response <= '0;
            axi_read_data_last     <= 1'b0;
            axi_read_data_valid    <= 1'b0;
        end else begin
            unique case (r_state)
                RIdle: begin
                    axi_read_address_ready <= 1'b1;
                    if (axi_read_address_valid && axi_read_address_ready) begin
                        r_id                   <= axi_read_address_id;
                        r_addr                 <= axi_read_address;
                        r_len                  <= axi_read_address_length;
                        r_size                 <= axi_read_address_size;
                        r_burst                <= axi_read_address_burst;
                        r_beat                 <= '0;
                        axi_read_address_ready <= 1'b0;
                        r_state                <= RAccess;
                    end
                end
                RAccess: begin
                    // Stall while a write beat owns the RAM port.
                    if (!write_grant) begin
                        axi_read_data_id       <= r_id;
                        axi_read_data_response <= r_resp_now;
                        axi_read_data          <= (r_resp_now == RESP_OKAY) ? mem[r_idx] : 32'd0;
                        axi_read_data_last     <= (r_beat == r_len);
                        axi_read_data_valid    <= 1'b1;
                        r_state                <= RData;
                    end
                end
                RData: begin
                    if (axi_read_data_ready) begin
                        axi_read_data_valid <= 1'b0;
                        if (axi_read_data_last) begin
                            axi_read_address_ready <= 1'b1;
                            r_state                <= RIdle;
                        end else begin
                            r_addr  <= next_addr(r_addr, r_size, r_burst);
                            r_beat  <= r_beat + 8'd1;
                            r_state <= RAccess;
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            w_state                  <= WIdle;
            axi_write_address_ready  <= 1'b0;
            w_addr                   <= '0;
            w_len                    <= '0;
            w_size                   <= '0;
            w_burst                  <= '0;
            w_beat                   <= '0;
            w_err                    <= '0;
            axi_write_responce_id    <= '0;
            axi_write_responce       <= '0;
            axi_write_responce_valid <= 1'b0;
        end else begin
            unique case (w_state)
                WIdle: begin
                    axi_write_address_ready <= 1'b1;
                    if (axi_write_address_valid && axi_write_address_ready) begin
                        axi_write_responce_id   <= axi_write_address_id;
                        w_addr                  <= axi_write_address;
                        w_len                   <= axi_write_address_length;
                        w_size                  <= axi_write_address_size;
                        w_burst                 <= axi_write_address_burst;
                        w_beat                  <= '0;
                        w_err                   <= RESP_OKAY;
                        axi_write_address_ready <= 1'b0;
                        w_state                 <= WData;
                    end
                end
                WData: begin
                    if (axi_write_data_valid) begin
                        w_err  <= worst(w_err, w_beat_err);
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_beat <= w_beat + 8'd1;
                        // Beat count alone terminates the burst; WLAST only feeds BRESP.
                        if (w_final) begin
                            axi_write_responce       <= worst(w_err, w_beat_err);
                            axi_write_responce_valid <= 1'b1;
                            w_state                  <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (axi_write_responce_ready) begin
                        axi_write_responce_valid <= 1'b0;
                        axi_write_address_ready  <= 1'b1;
                        w_state                  <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: single-beat vector table plus hand-written
// burst, arbitration and mid-burst reset sequences.
module tb_axi_ram_slave;

    logic        clock = 1'b0;
    logic        reset_;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    axi_ram_slave #(.RAM_DEPTH_LOG2(12)) dut (
        .clock                    (clock),
        .reset_                   (reset_),
        .axi_read_address_id      (arid),
        .axi_read_address         (araddr),
        .axi_read_address_length  (arlen),
        .axi_read_address_size    (arsize),
        .axi_read_address_burst   (arburst),
        .axi_read_address_valid   (arvalid),
        .axi_read_address_ready   (arready),
        .axi_read_data_id         (rid),
        .axi_read_data            (rdata),
        .axi_read_data_response   (rresp),
        .axi_read_data_last       (rlast),
        .axi_read_data_valid      (rvalid),
        .axi_read_data_ready      (rready),
        .axi_write_address_id     (awid),
        .axi_write_address        (awaddr),
        .axi_write_address_length (awlen),
        .axi_write_address_size   (awsize),
        .axi_write_address_burst  (awburst),
        .axi_write_address_valid  (awvalid),
        .axi_write_address_ready  (awready),
        .axi_write_data_id        (wid),
        .axi_write_data           (wdata),
        .axi_write_data_strobe    (wstrb),
        .axi_write_data_last      (wlast),
        .axi_write_data_valid     (wvalid),
        .axi_write_data_ready     (wready),
        .axi_write_responce_id    (bid),
        .axi_write_responce       (bresp),
        .axi_write_responce_valid (bvalid),
        .axi_write_responce_ready (bready)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) timeout("ar_wait");
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) timeout("aw_wait");
        @(negedge clock);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) timeout("w_wait");
        @(negedge clock);
        wvalid = 1'b0;
    endtask

    task automatic get_b(output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) timeout("b_wait");
        id = bid; resp = bresp;
        @(negedge clock);
        bready = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] data, output logic [1:0] resp,
                         output logic [3:0] id, output logic last);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) timeout("r_wait");
        data = rdata; resp = rresp; id = rid; last = rlast;
        @(negedge clock);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  rs;
        logic [3:0]  id;
        logic        l;
        logic        stale;
        int          n;

        reset_ = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        //           wr  addr           sz    strb     data           last  id    resp   rdata
        vecs.push_back('{1, 32'h10,       3'd2, 4'hF, 32'hDEADBEEF, 1'b1, 4'd5, 2'b00, 32'h0});
        vecs.push_back('{0, 32'h10,       3'd2, 4'h0, 32'h0,        1'b1, 4'd3, 2'b00, 32'hDEADBEEF});
        vecs.push_back('{1, 32'h10,       3'd2, 4'h4, 32'h11223344, 1'b1, 4'd1, 2'b00, 32'h0});
        vecs.push_back('{0, 32'h10,       3'd2, 4'h0, 32'h0,        1'b1, 4'd2, 2'b00, 32'hDE22BEEF});
        vecs.push_back('{1, 32'h10,       3'd2, 4'h1, 32'h000000AA, 1'b1, 4'd6, 2'b00, 32'h0});
        vecs.push_back('{0, 32'h10,       3'd2, 4'h0, 32'h0,        1'b1, 4'd4, 2'b00, 32'hDE22BEAA});
        vecs.push_back('{1, 32'h0,        3'd2, 4'hF, 32'hCAFEF00D, 1'b1, 4'd7, 2'b00, 32'h0});
        vecs.push_back('{1, 32'h80000000, 3'd2, 4'hF, 32'hFFFFFFFF, 1'b1, 4'd8, 2'b11, 32'h0});
        vecs.push_back('{0, 32'h80000000, 3'd2, 4'h0, 32'h0,        1'b1, 4'd9, 2'b11, 32'h0});
        vecs.push_back('{0, 32'h0,        3'd2, 4'h0, 32'h0,        1'b1, 4'd1, 2'b00, 32'hCAFEF00D});
        vecs.push_back('{1, 32'h0,        3'd3, 4'hF, 32'h12345678, 1'b1, 4'd2, 2'b10, 32'h0});
        vecs.push_back('{0, 32'h0,        3'd3, 4'h0, 32'h0,        1'b1, 4'd3, 2'b10, 32'h0});
        vecs.push_back('{0, 32'h0,        3'd2, 4'h0, 32'h0,        1'b1, 4'd4, 2'b00, 32'hCAFEF00D});
        vecs.push_back('{1, 32'h3FFC,     3'd2, 4'hF, 32'h0BADCAFE, 1'b1, 4'd5, 2'b00, 32'h0});
        vecs.push_back('{0, 32'h3FFC,     3'd2, 4'h0, 32'h0,        1'b1, 4'd6, 2'b00, 32'h0BADCAFE});
        vecs.push_back('{0, 32'h4000,     3'd2, 4'h0, 32'h0,        1'b1, 4'd7, 2'b11, 32'h0});
        vecs.push_back('{0, 32'h4000,     3'd3, 4'h0, 32'h0,        1'b1, 4'd8, 2'b11, 32'h0});
        vecs.push_back('{1, 32'h30,       3'd2, 4'hF, 32'h55555555, 1'b0, 4'd9, 2'b10, 32'h0});
        vecs.push_back('{1, 32'h40,       3'd2, 4'hF, 32'h00000000, 1'b1, 4'd3, 2'b00, 32'h0});

        // Reset state
        #12;
        check("reset_arready", {31'd0, arready}, 32'd0);
        check("reset_awready", {31'd0, awready}, 32'd0);
        check("reset_rvalid",  {31'd0, rvalid},  32'd0);
        check("reset_bvalid",  {31'd0, bvalid},  32'd0);
        check("reset_wready",  {31'd0, wready},  32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        check("arready_after_release", {31'd0, arready}, 32'd1);
        check("awready_after_release", {31'd0, awready}, 32'd1);
        @(negedge clock);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                send_aw(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, 2'b01);
                send_w(vecs[i].data, vecs[i].strb, vecs[i].last);
                get_b(id, rs);
                check($sformatf("vec%0d_bid", i), {28'd0, id}, {28'd0, vecs[i].id});
                check($sformatf("vec%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].resp});
            end else begin
                send_ar(vecs[i].id, vecs[i].addr, 8'd0, vecs[i].size, 2'b01);
                get_r(d, rs, id, l);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
                check($sformatf("vec%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].resp});
                check($sformatf("vec%0d_rid", i), {28'd0, id}, {28'd0, vecs[i].id});
                check($sformatf("vec%0d_rlast", i), {31'd0, l}, 32'd1);
            end
        end

        // INCR write burst, then read it back with RREADY held low for one cycle per beat
        send_aw(4'd1, 32'h20, 8'd3, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++) send_w(32'(k + 1), 4'hF, k == 3);
        get_b(id, rs);
        check("burst_bresp", {30'd0, rs}, 32'd0);
        send_ar(4'd7, 32'h20, 8'd3, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rvalid && n < 100) begin @(negedge clock); n++; end
            if (n >= 100) timeout("burst_r_wait");
            d = rdata;
            check($sformatf("burst_rdata%0d", k), rdata, 32'(k + 1));
            check($sformatf("burst_rlast%0d", k), {31'd0, rlast}, {31'd0, k == 3});
            check($sformatf("burst_rid%0d", k), {28'd0, rid}, 32'd7);
            @(negedge clock);
            check($sformatf("burst_hold_rvalid%0d", k), {31'd0, rvalid}, 32'd1);
            check($sformatf("burst_hold_rdata%0d", k), rdata, d);
            rready = 1'b1;
            @(negedge clock);
            rready = 1'b0;
        end

        // AR and AW in the same cycle; write beat must win the RAM port
        arid = 4'd9; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'd4; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        check("simul_ready_both", {30'd0, arready, awready}, 32'd3);
        arvalid = 1'b1; awvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0;
        check("simul_accepted", {30'd0, arready, awready}, 32'd0);
        check("simul_wready", {31'd0, wready}, 32'd1);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(negedge clock);
        wvalid = 1'b0;
        get_r(d, rs, id, l);
        check("simul_rdata", d, 32'hA5A5A5A5);
        check("simul_rid", {28'd0, id}, 32'd9);
        get_b(id, rs);
        check("simul_bid", {28'd0, id}, 32'd4);
        check("simul_bresp", {30'd0, rs}, 32'd0);

        // Asynchronous reset during beat 2 of a len3 read
        send_ar(4'd2, 32'h20, 8'd3, 3'd2, 2'b01);
        get_r(d, rs, id, l);
        check("rst_beat1", d, 32'd1);
        n = 0;
        while (!rvalid && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) timeout("rst_beat2_wait");
        check("rst_beat2_rvalid", {31'd0, rvalid}, 32'd1);
        #2 reset_ = 1'b0;
        #1;
        check("rst_async_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_async_rdata", rdata, 32'd0);
        check("rst_async_arready", {31'd0, arready}, 32'd0);
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        rready = 1'b1;
        @(posedge clock);
        #1;
        check("rst_release_arready", {31'd0, arready}, 32'd1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clock);
            stale = stale | rvalid;
        end
        rready = 1'b0;
        check("rst_no_stale_beats", {31'd0, stale}, 32'd0);
        send_ar(4'd5, 32'h2C, 8'd0, 3'd2, 2'b01);
        get_r(d, rs, id, l);
        check("rst_after_read", d, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- AXI3-style slave responder that terminates the CPU-side AXI master bridge.
- Backs read (AR/R) and write (AW/W/B) channels with an internal single-port, byte-writable word RAM.
- Used as the simulation and FPGA memory model behind the CPU AXI interface.
- Supports FIXED/INCR bursts up to 256 beats, echoes IDs, and reports OKAY/SLVERR/DECERR.

Parameters:
- RAM_DEPTH_LOG2, 12, log2 of number of 32-bit words; valid byte range is 0 .. 4*2^RAM_DEPTH_LOG2-1.

Ports:
- clock  in  1  single clock, rising edge
- reset_  in  1  asynchronous, active-low reset
- axi_read_address_id  in  4  ARID
- axi_read_address  in  32  ARADDR
- axi_read_address_length  in  8  ARLEN (beats-1)
- axi_read_address_size  in  3  ARSIZE
- axi_read_address_burst  in  2  ARBURST
- axi_read_address_valid  in  1  ARVALID
- axi_read_address_ready  out  1  ARREADY
- axi_read_data_id  out  4  RID
- axi_read_data  out  32  RDATA
- axi_read_data_response  out  2  RRESP
- axi_read_data_last  out  1  RLAST
- axi_read_data_valid  out  1  RVALID
- axi_read_data_ready  in  1  RREADY
- axi_write_address_id/_address/_length/_size/_burst  in  4/32/8/3/2  AW fields
- axi_write_address_valid  in  1  AWVALID
- axi_write_address_ready  out  1  AWREADY
- axi_write_data_id  in  4  WID (ignored)
- axi_write_data  in  32  WDATA
- axi_write_data_strobe  in  4  WSTRB
- axi_write_data_last  in  1  WLAST
- axi_write_data_valid  in  1  WVALID
- axi_write_data_ready  out  1  WREADY
- axi_write_responce_id  out  4  BID
- axi_write_responce  out  2  BRESP
- axi_write_responce_valid  out  1  BVALID
- axi_write_responce_ready  in  1  BREADY

Behaviour:
- Reset
  - While reset_ is low, every output is 0 and both FSMs return to idle immediately (asynchronous).
  - RAM contents are not reset.
  - ARREADY/AWREADY are registered and first read 1 after the first posedge following reset_ release.
- Read FSM
  - R_IDLE: ARREADY=1. On AR handshake, latch id/addr/len/size/burst, clear beat counter, go to R_ACCESS; ARREADY=0 from the next cycle.
  - R_ACCESS: issue a RAM read if the port is granted, go to R_DATA; if not granted, stay.
  - R_DATA: RVALID=1. RDATA, RID, RRESP and RLAST are registered and held stable until RREADY.
    - RLAST=1 only when beat==len.
    - On handshake at the last beat, go to R_IDLE; otherwise advance the address and go to R_ACCESS.
    - Throughput is one beat per 2 cycles minimum.
- Write FSM
  - W_IDLE: AWREADY=1. On AW handshake, latch fields, clear beat counter and error flag, go to W_DATA.
  - W_DATA: WREADY=1 when the RAM port is granted. On W handshake, write the bytes whose WSTRB bit is set, then advance the address and beat counter.
    - The beat with beat==len moves to W_RESP.
    - WLAST mismatch (set early, or clear on the final beat) sets SLVERR. Beat count alone ends the burst.
  - W_RESP: BVALID=1 with BID=latched AWID and the accumulated BRESP; hold until BREADY, then go to W_IDLE.
- Arbitration
  - One RAM port. A write beat (W_DATA & WVALID) has priority over R_ACCESS.
  - A read blocked by a write stalls in R_ACCESS and then returns post-write data.
- Addressing
  - Word index is addr[RAM_DEPTH_LOG2+1:2]; RDATA is always the full aligned word.
  - Burst 00 (FIXED) keeps the address unchanged; any other encoding is treated as INCR: addr += 1<<size, 32-bit wrap.
- Responses (per beat; BRESP keeps the highest-priority error seen)
  - DECERR 2'b11: any address bit above RAM_DEPTH_LOG2+1 is set. Reads return 0; writes are dropped.
  - SLVERR 2'b10: size>2. No RAM access; reads return 0.
  - OKAY 2'b00: otherwise.
  - Priority is DECERR > SLVERR > OKAY.
- Simultaneous events
  - AR and AW handshakes in the same cycle are both accepted.
  - R and B handshakes are independent.

Test Plan:
- Write len0 at 0x10, data 0xDEADBEEF, strobe 1111, AWID 5 -> BVALID, BID 5, BRESP 00. Then AR 0x10 with ARID 3 -> RDATA 0xDEADBEEF, RID 3, RLAST 1, RRESP 00.
- Write 0x11223344 with strobe 0100 at 0x10, then read 0x10 -> 0xDE22BEEF.
- INCR write len3 size2 at 0x20 with data 1,2,3,4, then read the burst with RREADY toggling 1,0,1,0 -> beats 1,2,3,4; RLAST only on beat 4; RDATA stable while RVALID&~RREADY.
- AR/AW to 0x80000000 -> RRESP 11 with RDATA 0, BRESP 11; a subsequent read of 0x0 shows unchanged data. Size=3 -> SLVERR.
- AR and AW to 0x40 in the same cycle, W data 0xA5A5A5A5 valid on the next cycle (old 0) -> write wins the port; read returns 0xA5A5A5A5.
- reset_ low during beat 2 of a len3 read -> RVALID drops to 0 without a clock. After release, ARREADY=1 at the first posedge and no stale beats appear.
